// File: rtl/imem_loader_pkg.sv
// Shared processor definitions: instruction-memory base address, word geometry
// and the loader state encoding used by the loader, instruction memory and PC unit.
package imem_loader_pkg;

    localparam logic [31:0] IMEM_BASE_ADDR = 32'h0040_0028;
    localparam int          BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_e;

endpackage

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into byte-wide instruction memory, little-endian.
// Latency: first byte strobe the cycle after acceptance; 5 cycles per word; in_ready low while writing.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = IMEM_BASE_ADDR,
    parameter int          MAX_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_word,
    input  logic        in_last,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_byte,
    output logic        busy,
    output logic        done,
    output logic [15:0] word_count,
    output logic        overflow
);

    localparam logic [15:0] MAX_W    = 16'(MAX_WORDS);
    localparam logic [31:0] WORD_INC = 32'(BYTES_PER_WORD);

    ld_state_e   state_q;
    logic [31:0] ptr_q;
    logic [31:0] word_q;
    logic        last_q;
    logic [1:0]  idx_q;
    logic [15:0] wc_q;
    logic        ovf_q;
    logic        in_ready_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [7:0]  mem_byte_q;
    logic        busy_q;
    logic        done_q;

    logic [1:0]  idx_d;
    logic [7:0]  byte_d;
    logic [31:0] addr_d;

    // Byte lane for the next strobe within the latched word.
    always_comb begin
        idx_d  = idx_q + 2'd1;
        addr_d = ptr_q + {30'd0, idx_d};
        byte_d = 8'h00;
        case (idx_d)
            2'd0: byte_d = word_q[7:0];
            2'd1: byte_d = word_q[15:8];
            2'd2: byte_d = word_q[23:16];
            2'd3: byte_d = word_q[31:24];
            default: byte_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 32'd0;
            word_q     <= 32'd0;
            last_q     <= 1'b0;
            idx_q      <= 2'd0;
            wc_q       <= 16'd0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 32'd0;
            mem_byte_q <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // Strobe-related outputs default low/zero; states below raise them.
            mem_we_q   <= 1'b0;
            mem_addr_q <= 32'd0;
            mem_byte_q <= 8'd0;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_LOAD;
                        ptr_q      <= BASE_ADDR;
                        wc_q       <= 16'd0;
                        ovf_q      <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (wc_q < MAX_W) begin
                            word_q     <= in_word;
                            last_q     <= in_last;
                            idx_q      <= 2'd0;
                            state_q    <= ST_WRITE;
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= ptr_q;
                            mem_byte_q <= in_word[7:0];
                        end else begin
                            ovf_q   <= 1'b1;
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (idx_q != 2'd3) begin
                        idx_q      <= idx_d;
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= addr_d;
                        mem_byte_q <= byte_d;
                    end else begin
                        ptr_q <= ptr_q + WORD_INC;
                        wc_q  <= wc_q + 16'd1;
                        if (last_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ST_LOAD;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_byte   = mem_byte_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign word_count = wc_q;
    assign overflow   = ovf_q;

endmodule
